// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate: bias + sum(x*w) over N_IN beats in Q.20, floored and
// clamped back to Q6.10 for the sigmoid stage.
module neuron_mac #(
    parameter int N_IN  = 16,
    parameter int ACC_W = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] bias,
    input  logic        in_valid,
    input  logic [15:0] x_in,
    input  logic [15:0] w_in,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] net_out,
    output logic        busy
);
    // state | meaning
    // IDLE  | waiting for start; bias loaded into acc on the start edge
    // ACC   | accepting x/w beats, stalls while in_valid is low
    // SAT   | one cycle: floor-shift acc to Q.10 and clamp into net_out
    // OUT   | result presented until out_ready
    typedef enum logic [1:0] {IDLE, ACC, SAT, OUT} state_t;

    localparam int CNT_W = $clog2(N_IN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_IN - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(32768));

    state_t                    r_state;
    state_t                    w_next;
    logic signed [ACC_W-1:0]   r_acc;
    logic        [CNT_W-1:0]   r_cnt;
    logic        [15:0]        r_net;
    logic signed [31:0]        w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_bias_ext;
    logic signed [ACC_W-1:0]   w_shr;
    logic        [15:0]        w_sat;
    logic                      w_xfer;

    assign w_prod     = $signed(x_in) * $signed(w_in);
    assign w_prod_ext = {{(ACC_W-32){w_prod[31]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-26){bias[15]}}, bias, 10'b0};
    assign w_shr      = r_acc >>> 10;
    assign w_xfer     = (r_state == ACC) && in_valid;

    always_comb begin
        w_sat = w_shr[15:0];
        if (w_shr > SAT_MAX) begin
            w_sat = 16'h7FFF;
        end else if (w_shr < SAT_MIN) begin
            w_sat = 16'h8000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = ACC;
            ACC:  if (w_xfer && (r_cnt == LAST_BEAT)) w_next = SAT;
            SAT:  w_next = OUT;
            OUT:  if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ACC);
        out_valid = (r_state == OUT);
        busy      = (r_state != IDLE);
        net_out   = r_net;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_net <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc <= w_bias_ext;
                        r_cnt <= '0;
                    end
                end
                ACC: begin
                    if (w_xfer) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SAT:     r_net <= w_sat;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac.sv
// Randomised bench for neuron_mac: two instances (N_IN=4 and N_IN=16) checked
// against a plain integer reference of bias + sum(x*w), floored and clamped.
module tb_neuron_mac;
    logic        clk;
    logic        rst_n;
    logic        start_drv;
    logic [15:0] bias;
    logic        in_valid;
    logic [15:0] x_in;
    logic [15:0] w_in;
    logic        out_ready;
    int          cur_sel;

    logic        start4, start16;
    logic        in_ready4, out_valid4, busy4;
    logic        in_ready16, out_valid16, busy16;
    logic [15:0] net_out4, net_out16;
    logic        s_in_ready, s_out_valid, s_busy;
    logic [15:0] s_net_out;

    logic [15:0] xv[64];
    logic [15:0] wv[64];
    int          n_tests;
    int          n_fail;

    neuron_mac #(.N_IN(4), .ACC_W(40)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .bias(bias),
        .in_valid(in_valid), .x_in(x_in), .w_in(w_in), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_ready(out_ready), .net_out(net_out4), .busy(busy4)
    );

    neuron_mac #(.N_IN(16), .ACC_W(40)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .bias(bias),
        .in_valid(in_valid), .x_in(x_in), .w_in(w_in), .in_ready(in_ready16),
        .out_valid(out_valid16), .out_ready(out_ready), .net_out(net_out16), .busy(busy16)
    );

    assign start4  = start_drv && (cur_sel == 4);
    assign start16 = start_drv && (cur_sel == 16);

    always_comb begin
        if (cur_sel == 16) begin
            s_in_ready = in_ready16; s_out_valid = out_valid16;
            s_busy = busy16; s_net_out = net_out16;
        end else begin
            s_in_ready = in_ready4; s_out_valid = out_valid4;
            s_busy = busy4; s_net_out = net_out4;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact sum in Q.20, floor to Q.10, saturate to 16 bits.
    function automatic logic [15:0] model(input int n, input logic [15:0] b);
        longint acc;
        longint q;
        acc = longint'($signed(b)) * 1024;
        for (int i = 0; i < n; i++)
            acc += longint'($signed(xv[i])) * longint'($signed(wv[i]));
        q = acc >>> 10;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one evaluation; entered and left at posedge+1.
    task automatic run_neuron(input int sel, input int n, input logic [15:0] b,
                              input int gap_max, input int hold, input bit poke,
                              output logic [15:0] res);
        cur_sel   = sel;
        bias      = b;
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
        bias      = 16'($urandom);
        check("busy_after_start", 32'(s_busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) begin
                int g;
                g = int'($urandom_range(gap_max, 0));
                for (int k = 0; k < g; k++) begin
                    in_valid = 1'b0;
                    x_in = 16'($urandom);
                    w_in = 16'($urandom);
                    tick();
                end
            end
            in_valid = 1'b1;
            x_in = xv[i];
            w_in = wv[i];
            if (i == 0 || i == n - 1) check("in_ready_acc", 32'(s_in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        check("in_ready_after_last", 32'(s_in_ready), 32'd0);
        check("out_valid_sat_cycle", 32'(s_out_valid), 32'd0);
        tick();
        check("out_valid_latency", 32'(s_out_valid), 32'd1);
        res = s_net_out;
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start_drv = poke && (h == 1);
            tick();
            start_drv = 1'b0;
            if (h == hold - 1) begin
                check("out_valid_hold", 32'(s_out_valid), 32'd1);
                check("net_out_stable", 32'(s_net_out), 32'(res));
            end
        end
        out_ready = 1'b1;
        start_drv = poke;
        tick();
        out_ready = 1'b0;
        start_drv = 1'b0;
        check("out_valid_drop", 32'(s_out_valid), 32'd0);
        check("idle_after_handshake", 32'(s_busy), 32'd0);
        check("net_out_retained", 32'(s_net_out), 32'(res));
    endtask

    task automatic fill(input int n, input logic [15:0] x, input logic [15:0] w);
        for (int i = 0; i < n; i++) begin
            xv[i] = x;
            wv[i] = w;
        end
    endtask

    initial begin
        logic [15:0] res;
        logic [15:0] exp_v;
        logic [15:0] rb;
        n_tests = 0;
        n_fail = 0;
        cur_sel = 4;
        start_drv = 1'b0;
        bias = 16'h0;
        in_valid = 1'b0;
        x_in = 16'h0;
        w_in = 16'h0;
        out_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'({out_valid4, out_valid16}), 32'd0);
        check("rst_in_ready", 32'({in_ready4, in_ready16}), 32'd0);
        check("rst_busy", 32'({busy4, busy16}), 32'd0);
        check("rst_net_out", 32'({net_out4, net_out16}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        fill(4, 16'h0400, 16'h0200);
        run_neuron(4, 4, 16'h0000, 0, 1, 1'b0, res);
        check("basic_sum", 32'(res), 32'h0800);

        fill(4, 16'hFC00, 16'h0400);
        run_neuron(4, 4, 16'h0400, 0, 1, 1'b0, res);
        check("neg_sum", 32'(res), 32'hF400);

        fill(16, 16'h7FFF, 16'h7FFF);
        run_neuron(16, 16, 16'h7FFF, 0, 1, 1'b0, res);
        check("sat_pos", 32'(res), 32'h7FFF);

        fill(16, 16'h8000, 16'h7FFF);
        run_neuron(16, 16, 16'h0000, 0, 1, 1'b0, res);
        check("sat_neg", 32'(res), 32'h8000);

        fill(4, 16'h0000, 16'h0000);
        xv[0] = 16'h0001;
        wv[0] = 16'hFFFF;
        run_neuron(4, 4, 16'h0000, 0, 1, 1'b0, res);
        check("floor_tiny_neg", 32'(res), 32'hFFFF);

        for (int t = 0; t < 8; t++) begin
            int sel;
            int n;
            logic [15:0] res_gap;
            sel = (t % 2 == 0) ? 4 : 16;
            n = sel;
            for (int i = 0; i < n; i++) begin
                xv[i] = (t < 4) ? 16'($urandom_range(4095, 0) - 2048) : 16'($urandom);
                wv[i] = (t < 4) ? 16'($urandom_range(4095, 0) - 2048) : 16'($urandom);
            end
            rb = 16'($urandom);
            exp_v = model(n, rb);
            run_neuron(sel, n, rb, 0, 1, 1'b0, res);
            check("rand_gapfree", 32'(res), 32'(exp_v));
            run_neuron(sel, n, rb, 3, 5, 1'b1, res_gap);
            check("rand_gaps_eq", 32'(res_gap), 32'(res));
        end

        cur_sel = 4;
        fill(4, 16'h7FFF, 16'h7FFF);
        bias = 16'h7FFF;
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            x_in = xv[i];
            w_in = wv[i];
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready4), 32'd0);
        check("midrst_busy", 32'(busy4), 32'd0);
        check("midrst_out_valid", 32'(out_valid4), 32'd0);
        check("midrst_net_out", 32'(net_out4), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("midrst_stays_idle", 32'({busy4, out_valid4}), 32'd0);
        fill(4, 16'h0400, 16'h0200);
        exp_v = model(4, 16'h0000);
        run_neuron(4, 4, 16'h0000, 0, 1, 1'b0, res);
        check("after_rst_run", 32'(res), 32'(exp_v));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end
endmodule
